// File: rtl/ofs_plat_avalon_mem_burst_split.sv
// Splits upstream Avalon-MM bursts into bank-legal sub-bursts of at most 2^(DST_BURST_W-1) lines.
// Latency: first sub-command/beat forwarded combinationally; remaining read sub-commands one per accepted cycle.
// Backpressure: bank waitrequest passes upstream; upstream is held off while read sub-commands drain.
module ofs_plat_avalon_mem_burst_split #(
    parameter int ADDR_W        = 27,
    parameter int DATA_W        = 512,
    parameter int SRC_BURST_W   = 12,
    parameter int DST_BURST_W   = 7,
    parameter int NATURAL_ALIGN = 0,
    parameter int BE_W          = DATA_W / 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      avs_address,
    input  logic [SRC_BURST_W-1:0] avs_burstcount,
    input  logic                   avs_read,
    input  logic                   avs_write,
    input  logic [DATA_W-1:0]      avs_writedata,
    input  logic [BE_W-1:0]        avs_byteenable,
    output logic                   avs_waitrequest,
    output logic [DATA_W-1:0]      avs_readdata,
    output logic                   avs_readdatavalid,
    output logic [ADDR_W-1:0]      avm_address,
    output logic [DST_BURST_W-1:0] avm_burstcount,
    output logic                   avm_read,
    output logic                   avm_write,
    output logic [DATA_W-1:0]      avm_writedata,
    output logic [BE_W-1:0]        avm_byteenable,
    input  logic                   avm_waitrequest,
    input  logic [DATA_W-1:0]      avm_readdata,
    input  logic                   avm_readdatavalid
);
    localparam int M = 1 << (DST_BURST_W - 1);
    localparam logic [SRC_BURST_W-1:0] M_S     = SRC_BURST_W'(M);
    localparam logic [SRC_BURST_W-1:0] ONE_S   = SRC_BURST_W'(1);
    localparam logic [DST_BURST_W-1:0] ONE_D   = DST_BURST_W'(1);

    typedef enum logic [1:0] {IDLE, RD_SPLIT, WR_BURST} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      next_addr_q, next_addr_d;
    logic [SRC_BURST_W-1:0] rem_q, rem_d;
    logic [DST_BURST_W-1:0] sub_left_q, sub_left_d;
    logic [DST_BURST_W-1:0] len_idle, len_reg;

    // With alignment, the limit is the distance to the next M-line boundary.
    function automatic logic [DST_BURST_W-1:0] sub_len(input logic [SRC_BURST_W-1:0] r,
                                                        input logic [DST_BURST_W-2:0] off);
        logic [SRC_BURST_W-1:0] lim;
        lim = M_S;
        if (NATURAL_ALIGN != 0) lim = M_S - SRC_BURST_W'(off);
        return (r < lim) ? DST_BURST_W'(r) : DST_BURST_W'(lim);
    endfunction

    assign len_idle = sub_len(avs_burstcount, avs_address[DST_BURST_W-2:0]);
    assign len_reg  = sub_len(rem_q, next_addr_q[DST_BURST_W-2:0]);

    assign avm_writedata     = avs_writedata;
    assign avm_byteenable    = avs_byteenable;
    assign avs_readdata      = avm_readdata;
    assign avs_readdatavalid = avm_readdatavalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            next_addr_q <= '0;
            rem_q       <= '0;
            sub_left_q  <= '0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            rem_q       <= rem_d;
            sub_left_q  <= sub_left_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        next_addr_d     = next_addr_q;
        rem_d           = rem_q;
        sub_left_d      = sub_left_q;
        avm_read        = 1'b0;
        avm_write       = 1'b0;
        avm_address     = next_addr_q;
        avm_burstcount  = len_reg;
        avs_waitrequest = 1'b1;
        case (state_q)
            IDLE: begin
                avm_address     = avs_address;
                avm_burstcount  = len_idle;
                avm_read        = avs_read;
                avm_write       = avs_write && !avs_read;
                avs_waitrequest = avm_waitrequest;
                if (avs_read && !avm_waitrequest) begin
                    rem_d       = avs_burstcount - SRC_BURST_W'(len_idle);
                    next_addr_d = avs_address + ADDR_W'(len_idle);
                    if (rem_d != '0) state_d = RD_SPLIT;
                end else if (avs_write && !avm_waitrequest) begin
                    sub_left_d  = len_idle - ONE_D;
                    rem_d       = avs_burstcount - ONE_S;
                    next_addr_d = avs_address + ADDR_W'(len_idle);
                    if (rem_d != '0) state_d = WR_BURST;
                end
            end
            RD_SPLIT: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    next_addr_d = next_addr_q + ADDR_W'(len_reg);
                    rem_d       = rem_q - SRC_BURST_W'(len_reg);
                    if (rem_d == '0) state_d = IDLE;
                end
            end
            WR_BURST: begin
                avm_write       = avs_write;
                // A stray read here sees waitrequest until the write burst completes.
                avs_waitrequest = avm_waitrequest || !avs_write;
                if (avs_write && !avm_waitrequest) begin
                    rem_d = rem_q - ONE_S;
                    if (sub_left_q == '0) begin
                        sub_left_d  = len_reg - ONE_D;
                        next_addr_d = next_addr_q + ADDR_W'(len_reg);
                    end else begin
                        sub_left_d = sub_left_q - ONE_D;
                    end
                    if (rem_d == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            avm_read        = 1'b0;
            avm_write       = 1'b0;
            avs_waitrequest = 1'b1;
        end
    end

    a_nonzero_len: assert property (@(posedge clk) disable iff (reset)
        (state_q == IDLE && (avs_read || avs_write)) |-> (avs_burstcount != '0));
    a_rd_wr_excl: assert property (@(posedge clk) !(avm_read && avm_write));
endmodule
